fifo_request: RTL and testbench

- Per-port input FIFO that sits directly upstream of the round-robin arbiter. Two instances exist, one per port.
- Buffers incoming words and raises `request` to the arbiter while it holds data.
- Pops one word per arbiter `pop` and presents that word, registered, to the downstream 2x1 mux.
- Reports almost-full/almost-empty watermarks for flow control and a sticky error flag for overflow/underflow.

---
 rtl/fifo_request.sv | 62 ++++++
 tb/tb_fifo_request.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fifo_request.sv
// fifo_request: per-port input FIFO feeding the round-robin arbiter, with registered pop output,
// watermarks and a sticky overflow/underflow flag.
module fifo_request #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  request,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign empty        = count == '0;
    assign full         = count == (ADDR_WIDTH+1)'(DEPTH);
    assign almost_full  = count >= (ADDR_WIDTH+1)'(AF_THRESH);
    assign almost_empty = count <= (ADDR_WIDTH+1)'(AE_THRESH);
    assign request      = !empty;
    assign do_pop       = pop && !empty;
    // a full FIFO still accepts a push when the same edge frees a slot
    assign do_push      = push && (!full || do_pop);

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= data_in;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid_out <= do_pop;
            error     <= error | (push && !do_push) | (pop && empty);
            if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (do_pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (do_push && !do_pop) count <= count + (ADDR_WIDTH+1)'(1);
            else if (do_pop && !do_push) count <= count - (ADDR_WIDTH+1)'(1);
        end
    end
endmodule

// File: tb/tb_fifo_request.sv
// tb_fifo_request: queue-model scoreboard bench for fifo_request.
module tb_fifo_request;
    logic       clk = 1'b0, reset_L = 1'b0, push = 1'b0, pop = 1'b0;
    logic [5:0] data_in = '0, data_out;
    logic       valid_out, request, full, empty, almost_full, almost_empty, error;
    logic [2:0] count;

    int errors = 0, checks = 0;
    logic [5:0] mq[$];
    logic [5:0] sb[$];
    logic       exp_err = 1'b0, exp_valid = 1'b0;
    logic [5:0] exp_data = '0;

    fifo_request dut (
        .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .valid_out(valid_out), .request(request), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .error(error), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_status();
        int n = mq.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == 4));
        check("almost_full", 32'(almost_full), 32'(n >= 3));
        check("almost_empty", 32'(almost_empty), 32'(n <= 1));
        check("request", 32'(request), 32'(n != 0));
        check("error", 32'(error), 32'(exp_err));
        check("valid_out", 32'(valid_out), 32'(exp_valid));
        check("data_out_hold", 32'(data_out), 32'(exp_data));
    endtask

    task automatic clear_model();
        mq.delete();
        sb.delete();
        exp_err = 1'b0;
        exp_valid = 1'b0;
        exp_data = '0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_status();
        reset_L = 1'b1;
    endtask

    task automatic cycle(input logic p, input logic [5:0] d, input logic q);
        bit dp, dq;
        push = p;
        data_in = d;
        pop = q;
        dq = q && mq.size() > 0;
        dp = p && (mq.size() < 4 || dq);
        exp_err = exp_err | (p && !dp) | (q && mq.size() == 0);
        exp_valid = dq;
        if (dq) begin
            exp_data = mq.pop_front();
            sb.push_back(exp_data);
        end
        if (dp) mq.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        check_status();
        if (valid_out === 1'b1) begin
            if (sb.size() == 0) check("sb_empty", 32'(data_out), 32'hffff_ffff);
            else check("sb_data", 32'(data_out), 32'(sb.pop_front()));
        end
    endtask

    initial begin
        do_reset();
        // fill, then overflow with 0x05
        for (int i = 1; i <= 4; i++) cycle(1'b1, 6'(i), 1'b0);
        cycle(1'b1, 6'h05, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        // underflow from reset
        do_reset();
        cycle(1'b0, '0, 1'b1);
        // push+pop while empty, then simultaneous stream with wrap
        do_reset();
        cycle(1'b1, 6'h3C, 1'b1);
        cycle(1'b0, '0, 1'b1);
        do_reset();
        cycle(1'b1, 6'h0A, 1'b0);
        cycle(1'b1, 6'h0B, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 6'(8'h10 + i), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        // push+pop while full keeps count at depth without error
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'(8'h20 + i), 1'b0);
        cycle(1'b1, 6'h30, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        // asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 6'(8'h31 + i), 1'b0);
        #2;
        reset_L = 1'b0;
        clear_model();
        #1;
        check_status();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        check_status();
        cycle(1'b1, 6'h2A, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("final_data", 32'(data_out), 32'h2A);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
